// File: rtl/legv8_regfile_mp.sv
// LEGv8 integer register file: NUM_RD registered read ports, one write port,
// hard-wired zero register, optional write-to-read bypass and a busy scoreboard.
module legv8_regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*AW-1:0]     i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_sb_set,
    input  logic [AW-1:0]            i_sb_addr,
    output logic [NUM_REGS-1:0]      o_busy_vec
);

    localparam logic [AW:0]   NREGS_A = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

    // An address is usable only if it exists and is not the zero register.
    function automatic logic addr_legal(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_A) && (a != ZERO_A);
    endfunction

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]      r_busy;
    logic [NUM_REGS-1:0]      w_busy_nxt;
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    logic [NUM_RD-1:0]        r_rd_busy;
    logic [NUM_RD*DATA_W-1:0] w_rd_data_nxt;
    logic [NUM_RD-1:0]        w_rd_busy_nxt;
    logic [AW-1:0]            w_rd_addr [NUM_RD];
    logic                     w_wr_ok;
    logic                     w_sb_ok;

    always_comb begin
        w_wr_ok = i_wr_en && addr_legal(i_wr_addr);
        w_sb_ok = i_sb_set && addr_legal(i_sb_addr);
    end

    // Set is applied after clear so a newly issued producer wins the tie.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)
            w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_sb_ok)
            w_busy_nxt[i_sb_addr] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_regs[r] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok)
                r_regs[i_wr_addr] <= i_wr_data;
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_addr[p]                       = i_rd_addr[p*AW +: AW];
            w_rd_data_nxt[p*DATA_W +: DATA_W]  = '0;
            w_rd_busy_nxt[p]                   = 1'b0;
            if (addr_legal(w_rd_addr[p])) begin
                if ((BYPASS != 0) && w_wr_ok && (w_rd_addr[p] == i_wr_addr)) begin
                    w_rd_data_nxt[p*DATA_W +: DATA_W] = i_wr_data;
                end else begin
                    w_rd_data_nxt[p*DATA_W +: DATA_W] = r_regs[w_rd_addr[p]];
                    w_rd_busy_nxt[p]                  = r_busy[w_rd_addr[p]];
                end
            end
        end
    end

    // Disabled ports keep their last captured data and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (i_rd_en[p]) begin
                    r_rd_data[p*DATA_W +: DATA_W] <= w_rd_data_nxt[p*DATA_W +: DATA_W];
                    r_rd_busy[p]                  <= w_rd_busy_nxt[p];
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_busy  = r_rd_busy;
    assign o_busy_vec = r_busy;

endmodule

// File: doc/legv8_regfile_mp.md
Name: legv8_regfile_mp

Overview:
Parametrised LEGv8 integer register file for the decode stage, with N registered read ports, one write port, XZR hard-wired to zero and optional write-to-read bypass. It also holds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers such as loads. Reads and writes are edge-synchronous, so the design has no level-sensitive clock use. It sits between fetch/decode and execute and is written from the writeback stage.

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 32, number of architectural registers; address width AW = $clog2(NUM_REGS)
NUM_RD, 2, number of read ports
ZERO_REG, 31, index that always reads 0, is never written and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the pre-write value

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed registered read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  registered busy flag for the address read on port i
wr_en  in  1  write enable (writeback)
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
sb_set  in  1  mark sb_addr busy (producer issued)
sb_addr  in  AW  scoreboard set address
busy_vec  out  NUM_REGS  current scoreboard state, bit r = register r busy

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - all registers = 0
  - rd_data = 0, rd_busy = 0, busy_vec = 0
  - all state held while rst_n is low
  - first update on the first rising clk edge after rst_n rises
- Write:
  - at posedge, if wr_en and wr_addr != ZERO_REG and wr_addr < NUM_REGS, regfile[wr_addr] <= wr_data
  - otherwise the write is ignored
- Read, per port i, latency 1 cycle:
  - at posedge with rd_en[i] = 1, rd_data[i] is loaded from the first matching rule:
    - addr == ZERO_REG or addr >= NUM_REGS -> 0
    - BYPASS = 1 and a legal write targets the same addr this cycle -> wr_data
    - otherwise -> regfile[addr], the pre-edge value
  - rd_en[i] = 0: rd_data[i] and rd_busy[i] hold their previous values
  - ports are fully independent; several ports on the same address return identical data
- Scoreboard, busy_vec:
  - a legal write to r clears bit r
  - sb_set to r sets bit r
  - set and clear of the same r in the same cycle: set wins (new producer issued)
  - sb_addr == ZERO_REG or >= NUM_REGS: ignored
  - busy_vec is a direct register output
- rd_busy[i], captured with rd_data[i]:
  - equals the pre-edge busy bit of addr
  - forced 0 when the read is bypassed from a same-cycle write (BYPASS = 1)
  - forced 0 for ZERO_REG or out-of-range addresses
  - an sb_set in the same cycle as the read does not make that read busy; the set is visible to reads from the next cycle
  - with BYPASS = 0, a read colliding with a same-cycle write returns the old value and the pre-edge busy bit
- Width rules:
  - no sign or zero extension here; data passes at DATA_W
  - immediate extension is a separate block
- No combinational path from any input to any output.

Test Plan:
- Reset then read: rst_n low mid-run, then released; read X0..X30 on both ports -> rd_data = 0 one cycle after each rd_en, busy_vec = 0; asserting rst_n between clock edges clears outputs immediately.
- Write/read latency: write X5 = 0x0123_4567_89AB_CDEF in cycle n, read X5 on port 0 in cycle n+1 -> rd_data[0] = 0x0123_4567_89AB_CDEF after edge n+2.
- XZR: write 0xFFFF_FFFF_FFFF_FFFF to X31, then read X31 and sb_set X31 -> rd_data = 0, rd_busy = 0, busy_vec[31] = 0.
- Bypass, BYPASS = 1: X7 holds 0x10; same cycle write X7 = 0x99 and read X7 on both ports -> both rd_data = 0x99.
  - Repeat with BYPASS = 0 -> both rd_data = 0x10, then 0x99 on the next read.
- Scoreboard: sb_set X3, next cycle read X3 -> rd_busy = 1, busy_vec[3] = 1; write X3 = 0x42 with a simultaneous read -> rd_busy = 0, rd_data = 0x42, busy_vec[3] = 0.
  - Then sb_set X3 together with a write to X3 in one cycle -> busy_vec[3] = 1.
- Hold / independence: NUM_RD = 3; port 1 rd_en = 0 while ports 0 and 2 read X1 = 0xA and X2 = 0xB -> port 1 holds its previous data; ports 0 and 2 update.
